sdram_buffer_sequencer: RTL and testbench

Sequences bursts between the 16-bit side of the 512×16 staging buffers and the SDRAM controller's data phase. A write job streams words out of the 32→16 buffer into the SDRAM write-data handshake, hiding the buffer's 1-cycle read latency with a 2-entry skid FIFO. A read job writes SDRAM read beats into the 16→32 buffer. It sits between the command logic, which issues jobs, and the SDRAM controller core.

---
 rtl/sdram_buffer_sequencer.sv | 175 +++++++++++++++++
 tb/tb_sdram_buffer_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_buffer_sequencer.sv
// Moves job bursts between the 16-bit staging buffer port and the SDRAM controller data phase.
// Write jobs prefetch through a 2-entry skid FIFO; read jobs register each beat into the buffer.
module sdram_buffer_sequencer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_WRITE,
  input  logic [ADDR_W-1:0] REQ_START,
  input  logic [ADDR_W-1:0] REQ_LEN_M1,
  output logic [ADDR_W-1:0] BUF_ADDR,
  input  logic [DATA_W-1:0] BUF_RD,
  output logic              BUF_WE,
  output logic [DATA_W-1:0] BUF_WD,
  output logic              SD_WVALID,
  input  logic              SD_WREADY,
  output logic [DATA_W-1:0] SD_WDATA,
  input  logic              SD_RVALID,
  input  logic [DATA_W-1:0] SD_RDATA,
  output logic              BUSY,
  output logic              DONE
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {StIdle, StWrRun, StRdRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   buf_addr_q, buf_addr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic                buf_we_q, buf_we_d;
  logic [DATA_W-1:0]   buf_wd_q, buf_wd_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic                in_flight_q, in_flight_d;
  logic [1:0]          occ_q, occ_d;
  logic [DATA_W-1:0]   fifo_q [2];
  logic [DATA_W-1:0]   fifo_d [2];
  logic                fifo_rd_q, fifo_rd_d;
  logic                fifo_wr_q, fifo_wr_d;

  logic                wr_run;
  logic                push;
  logic                pop;
  logic                issue;
  logic [2:0]          fill;
  logic [2:0]          limit;
  logic [CNT_W-1:0]    job_len;

  assign wr_run  = (state_q == StWrRun);
  assign push    = wr_run && in_flight_q;
  assign pop     = wr_run && (occ_q != 2'd0) && SD_WREADY;
  // Issue only if the word would still have a FIFO slot after this cycle's pop.
  assign fill    = {1'b0, occ_q} + {2'b00, in_flight_q};
  assign limit   = 3'd2 + {2'b00, pop};
  assign issue   = wr_run && (issue_cnt_q != '0) && (fill < limit);
  assign job_len = {1'b0, REQ_LEN_M1} + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    rd_ptr_d    = rd_ptr_q;
    buf_we_d    = 1'b0;
    buf_wd_d    = buf_wd_q;
    issue_cnt_d = issue_cnt_q;
    remain_d    = remain_q;
    in_flight_d = in_flight_q;
    occ_d       = occ_q;
    fifo_d      = fifo_q;
    fifo_rd_d   = fifo_rd_q;
    fifo_wr_d   = fifo_wr_q;

    unique case (state_q)
      StIdle: begin
        if (REQ_VALID) begin
          buf_addr_d  = REQ_START;
          rd_ptr_d    = REQ_START;
          issue_cnt_d = job_len;
          remain_d    = job_len;
          in_flight_d = 1'b0;
          occ_d       = 2'd0;
          fifo_rd_d   = 1'b0;
          fifo_wr_d   = 1'b0;
          state_d     = REQ_WRITE ? StWrRun : StRdRun;
        end
      end

      StWrRun: begin
        in_flight_d = issue;
        if (issue) begin
          buf_addr_d  = buf_addr_q + ADDR_W'(1);
          issue_cnt_d = issue_cnt_q - CNT_W'(1);
        end
        if (push) begin
          fifo_d[fifo_wr_q] = BUF_RD;
          fifo_wr_d         = ~fifo_wr_q;
        end
        if (pop) begin
          fifo_rd_d = ~fifo_rd_q;
          remain_d  = remain_q - CNT_W'(1);
        end
        occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        if (pop && (remain_q == CNT_W'(1))) begin
          state_d = StDone;
        end
      end

      StRdRun: begin
        // Counter hits zero on the last beat; the extra cycle lets BUF_WE precede DONE.
        if (remain_q == '0) begin
          state_d = StDone;
        end else if (SD_RVALID) begin
          buf_we_d   = 1'b1;
          buf_wd_d   = SD_RDATA;
          buf_addr_d = rd_ptr_q;
          rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
          remain_d   = remain_q - CNT_W'(1);
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      buf_addr_q  <= '0;
      rd_ptr_q    <= '0;
      buf_we_q    <= 1'b0;
      buf_wd_q    <= '0;
      issue_cnt_q <= '0;
      remain_q    <= '0;
      in_flight_q <= 1'b0;
      occ_q       <= 2'd0;
      fifo_q[0]   <= '0;
      fifo_q[1]   <= '0;
      fifo_rd_q   <= 1'b0;
      fifo_wr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      buf_we_q    <= buf_we_d;
      buf_wd_q    <= buf_wd_d;
      issue_cnt_q <= issue_cnt_d;
      remain_q    <= remain_d;
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      fifo_q[0]   <= fifo_d[0];
      fifo_q[1]   <= fifo_d[1];
      fifo_rd_q   <= fifo_rd_d;
      fifo_wr_q   <= fifo_wr_d;
    end
  end

  assign REQ_READY = (state_q == StIdle);
  assign BUSY      = (state_q != StIdle);
  assign DONE      = (state_q == StDone);
  assign BUF_ADDR  = buf_addr_q;
  assign BUF_WE    = buf_we_q;
  assign BUF_WD    = buf_wd_q;
  assign SD_WVALID = (occ_q != 2'd0);
  assign SD_WDATA  = fifo_q[fifo_rd_q];

endmodule

// File: tb/tb_sdram_buffer_sequencer.sv
// Directed bench for sdram_buffer_sequencer; the staging buffer returns 0x1000 + address
// one cycle after the address is presented.
module tb_sdram_buffer_sequencer;

  logic        CLK;
  logic        RST_N;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WRITE;
  logic [8:0]  REQ_START;
  logic [8:0]  REQ_LEN_M1;
  logic [8:0]  BUF_ADDR;
  logic [15:0] BUF_RD;
  logic        BUF_WE;
  logic [15:0] BUF_WD;
  logic        SD_WVALID;
  logic        SD_WREADY;
  logic [15:0] SD_WDATA;
  logic        SD_RVALID;
  logic [15:0] SD_RDATA;
  logic        BUSY;
  logic        DONE;

  int total = 0;
  int bad   = 0;

  sdram_buffer_sequencer #(
    .ADDR_W(9),
    .DATA_W(16)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_WRITE (REQ_WRITE),
    .REQ_START (REQ_START),
    .REQ_LEN_M1(REQ_LEN_M1),
    .BUF_ADDR  (BUF_ADDR),
    .BUF_RD    (BUF_RD),
    .BUF_WE    (BUF_WE),
    .BUF_WD    (BUF_WD),
    .SD_WVALID (SD_WVALID),
    .SD_WREADY (SD_WREADY),
    .SD_WDATA  (SD_WDATA),
    .SD_RVALID (SD_RVALID),
    .SD_RDATA  (SD_RDATA),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read buffer model: data for the sampled address appears after the edge.
  always @(posedge CLK) BUF_RD <= 16'h1000 + {7'd0, BUF_ADDR};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic wr, input logic [8:0] start, input logic [8:0] len);
    chk("req_ready_before", {31'd0, REQ_READY}, 32'd1);
    REQ_VALID  = 1'b1;
    REQ_WRITE  = wr;
    REQ_START  = start;
    REQ_LEN_M1 = len;
    tick();
    REQ_VALID  = 1'b0;
    REQ_START  = 9'h155;
    REQ_LEN_M1 = 9'h0aa;
    chk("accept_busy", {31'd0, BUSY}, 32'd1);
    chk("accept_addr", {23'd0, BUF_ADDR}, {23'd0, start});
  endtask

  // Runs a write job from the sample just after acceptance up to the DONE sample.
  task automatic run_write(input logic [8:0] start, input logic [8:0] len, input bit rnd);
    int          pops = 0;
    bit          exp_done = 0;
    bit          prev_stall = 0;
    bit          seen_valid = 0;
    bit          finished = 0;
    bit          pop;
    logic [15:0] prev_data = '0;
    logic [8:0]  ahead;
    logic [8:0]  a;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("wr_done", {31'd0, DONE}, {31'd0, exp_done});
      if (exp_done) begin
        chk("wr_done_not_ready", {31'd0, REQ_READY}, 32'd0);
        finished = 1;
        break;
      end
      if (prev_stall) begin
        chk("stall_valid", {31'd0, SD_WVALID}, 32'd1);
        chk("stall_data", {16'd0, SD_WDATA}, {16'd0, prev_data});
      end
      ahead = BUF_ADDR - start - pops[8:0];
      chk("addr_ahead_le2", {31'd0, (ahead <= 9'd2)}, 32'd1);
      if (SD_WVALID && !seen_valid) begin
        seen_valid = 1;
        chk("first_valid_cycle", cyc, 32'd2);
      end
      SD_WREADY = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      pop = SD_WVALID && SD_WREADY;
      if (pop) begin
        a = start + pops[8:0];
        chk("wdata", {16'd0, SD_WDATA}, 32'h1000 + {23'd0, a});
        if (!rnd) chk("pop_no_bubble", cyc, pops + 2);
        pops++;
      end
      exp_done   = pop && (pops == int'(len) + 1);
      prev_stall = SD_WVALID && !SD_WREADY;
      prev_data  = SD_WDATA;
      tick();
    end
    if (!finished) chk("wr_timeout", 32'd0, 32'd1);
    chk("wr_word_count", pops, int'(len) + 1);
    SD_WREADY = 1'b0;
  endtask

  // Runs a read job with a fixed gap pattern, up to the DONE sample.
  task automatic run_read(input logic [8:0] start, input logic [8:0] len);
    int          beats = 0;
    bit          exp_we = 0;
    bit          exp_done = 0;
    bit          finished = 0;
    bit          beat;
    logic [8:0]  exp_addr = '0;
    logic [15:0] exp_wd = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      chk("rd_we", {31'd0, BUF_WE}, {31'd0, exp_we});
      if (exp_we) begin
        chk("rd_addr", {23'd0, BUF_ADDR}, {23'd0, exp_addr});
        chk("rd_data", {16'd0, BUF_WD}, {16'd0, exp_wd});
      end
      chk("rd_done", {31'd0, DONE}, {31'd0, exp_done});
      if (exp_done) begin
        finished = 1;
        break;
      end
      exp_done = exp_we && (beats == int'(len) + 1);
      beat = (beats < int'(len) + 1) && ((cyc % 3) != 1);
      SD_RVALID = beat;
      SD_RDATA  = 16'h00A0 + beats[15:0];
      if (beat) begin
        exp_addr = start + beats[8:0];
        exp_wd   = SD_RDATA;
        beats++;
      end
      exp_we = beat;
      tick();
    end
    SD_RVALID = 1'b0;
    if (!finished) chk("rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic post_done();
    tick();
    chk("done_single_pulse", {31'd0, DONE}, 32'd0);
    chk("idle_after_done", {31'd0, REQ_READY}, 32'd1);
  endtask

  initial begin
    RST_N      = 1'b0;
    REQ_VALID  = 1'b0;
    REQ_WRITE  = 1'b0;
    REQ_START  = '0;
    REQ_LEN_M1 = '0;
    SD_WREADY  = 1'b0;
    SD_RVALID  = 1'b0;
    SD_RDATA   = '0;
    #12;
    chk("rst_ready", {31'd0, REQ_READY}, 32'd1);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_done", {31'd0, DONE}, 32'd0);
    chk("rst_wvalid", {31'd0, SD_WVALID}, 32'd0);
    chk("rst_wdata", {16'd0, SD_WDATA}, 32'd0);
    chk("rst_addr", {23'd0, BUF_ADDR}, 32'd0);
    chk("rst_we", {31'd0, BUF_WE}, 32'd0);
    chk("rst_wd", {16'd0, BUF_WD}, 32'd0);
    tick();
    RST_N = 1'b1;
    tick();

    // Full-rate 8-word write from address 0.
    accept(1'b1, 9'd0, 9'd7);
    run_write(9'd0, 9'd7, 1'b0);
    post_done();

    // 16-word write under random backpressure.
    accept(1'b1, 9'd300, 9'd15);
    run_write(9'd300, 9'd15, 1'b1);
    post_done();

    // Stray read beats while idle must not write the buffer.
    SD_RVALID = 1'b1;
    SD_RDATA  = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_no_we", {31'd0, BUF_WE}, 32'd0);
    end
    SD_RVALID = 1'b0;
    tick();

    // Wrapping read job, then a request already pending during DONE.
    accept(1'b0, 9'd510, 9'd3);
    run_read(9'd510, 9'd3);
    REQ_VALID  = 1'b1;
    REQ_WRITE  = 1'b1;
    REQ_START  = 9'd5;
    REQ_LEN_M1 = 9'd0;
    chk("done_blocks_req", {31'd0, REQ_READY}, 32'd0);
    tick();
    chk("gap_ready", {31'd0, REQ_READY}, 32'd1);
    chk("gap_busy", {31'd0, BUSY}, 32'd0);
    chk("gap_done", {31'd0, DONE}, 32'd0);
    tick();
    REQ_VALID = 1'b0;
    chk("held_accept_busy", {31'd0, BUSY}, 32'd1);
    chk("held_accept_addr", {23'd0, BUF_ADDR}, 32'd5);
    run_write(9'd5, 9'd0, 1'b0);
    post_done();

    // Reset in the middle of a stalled write with both FIFO entries filled.
    accept(1'b1, 9'd200, 9'd15);
    SD_WREADY = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_wvalid", {31'd0, SD_WVALID}, 32'd1);
    chk("pre_rst_addr", {23'd0, BUF_ADDR}, 32'd202);
    chk("pre_rst_wdata", {16'd0, SD_WDATA}, 32'h10C8);
    RST_N = 1'b0;
    #1;
    chk("mid_rst_wvalid", {31'd0, SD_WVALID}, 32'd0);
    chk("mid_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("mid_rst_ready", {31'd0, REQ_READY}, 32'd1);
    chk("mid_rst_addr", {23'd0, BUF_ADDR}, 32'd0);
    tick();
    chk("mid_rst_no_done", {31'd0, DONE}, 32'd0);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_no_done", {31'd0, DONE}, 32'd0);
      chk("post_rst_idle", {31'd0, BUSY}, 32'd0);
    end
    accept(1'b1, 9'd60, 9'd3);
    run_write(9'd60, 9'd3, 1'b0);
    post_done();

    // Maximum-length write wrapping through address 0.
    accept(1'b1, 9'd37, 9'd511);
    run_write(9'd37, 9'd511, 1'b0);
    post_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
